curve_param_ctrl: RTL and testbench
===================================

CURVE_PARAM_CTRL -- requirements
Module: curve_param_ctrl

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
- LREF_D, 88, reset value of lref_q
- K_D, 587, reset value of k_q
- PMAX_D, 587, reset value of pmax_q
- ALPHA_H_D, 561, reset value of alpha_h_q
- LB_D, 26, reset value of lb_q
- K2_D, 2040, reset value of k2_q
- SMOOTH_D, 0, reset value of smooth_k
- TIMEOUT, 24'd2000000, maximum PENDING cycles before a forced apply
REQ-002 SHALL have ports, one per line: name  direction  width  meaning:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- i_vs  in  1  video vsync at the curve pipeline input
- cfg_wr  in  1  write strobe, one beat per cycle
- cfg_addr  in  3  field select
- cfg_wdata  in  16  write data
- cfg_commit  in  1  request to apply the shadow set
- cfg_ready  out  1  high when writes and commit are accepted
- cfg_err  out  1  one-cycle pulse on a rejected write
- lref_q  out  8  active LREF
- k_q  out  12  active K
- pmax_q  out  12  active PMAX
- alpha_h_q  out  12  active ALPHA_H
- lb_q  out  8  active LB
- k2_q  out  12  active K2
- smooth_k  out  4  active smoothing factor
- bypass  out  1  active bypass select (1 = source RGB path)
- apply_pulse  out  1  one-cycle pulse when the active set is updated
- timeout_flag  out  1  sticky; set by a forced apply
- frame_cnt  out  16  count of vsync rising edges
REQ-003 SHALL use one clock, clk, with asynchronous active-low reset rst_n.

Function
REQ-004 SHALL hold a shadow register set and an active register set; all downstream outputs are driven only from the active set.
REQ-005 SHALL map cfg_addr: 0 lref, 1 k, 2 pmax, 3 alpha_h, 4 lb, 5 k2, 6 smooth_k, 7 bypass; each write takes the low field-width bits of cfg_wdata and discards the upper bits.
REQ-006 SHALL detect a vsync rising edge as i_vs high while the previous registered i_vs is low; i_vs is not synchronised (same clock domain).
REQ-007 SHALL have three FSM states: IDLE, PENDING, APPLY.
REQ-008 IDLE: cfg_ready=1; cfg_wr updates the shadow set on the same edge; cfg_commit moves to PENDING.
REQ-009 PENDING: cfg_ready=0; a cfg_wr is ignored and pulses cfg_err on the next cycle; a vsync rising edge moves to APPLY; the timeout counter increments each cycle.
REQ-010 PENDING: when the timeout counter reaches TIMEOUT-1 with no edge, SHALL move to APPLY and set timeout_flag.
REQ-011 APPLY: lasts one cycle; copies shadow to active on exiting APPLY; apply_pulse=1 on the cycle after; clears the timeout counter; returns to IDLE.
REQ-012 cfg_wr and cfg_commit in the same IDLE cycle SHALL include that write in the committed set.
REQ-013 A cfg_commit coinciding with a vsync rising edge in IDLE SHALL wait for the next edge; the coincident edge is not consumed.
REQ-014 cfg_commit in PENDING or APPLY SHALL be ignored without an error.
REQ-015 frame_cnt SHALL increment on every vsync rising edge in any state, wrapping from 65535 to 0.
REQ-016 timeout_flag SHALL clear only on reset or on a non-forced (edge-triggered) apply.
REQ-017 Latency SHALL be: vsync rising edge at cycle N in PENDING, new active values and apply_pulse visible at N+2.

Reset
REQ-018 On reset SHALL set: state IDLE; shadow and active sets to the *_D defaults; bypass=0; cfg_ready=1; cfg_err=0; apply_pulse=0; timeout_flag=0; frame_cnt=0; timeout counter=0.
REQ-019 Reset asserted in PENDING SHALL discard the pending shadow set; the defaults apply with no apply_pulse.

Verification
REQ-020 Bench SHALL cover these scenarios:
- Write addr1=700, commit, vsync edge at cycle N -> k_q=700 and apply_pulse=1 at N+2; k_q=587 before then.
- Write addr5=0xFFFF -> after apply, k2_q=4095.
- Commit, then write addr0=10 while PENDING -> cfg_err pulse, lref_q stays 88 after apply.
- Commit with i_vs held low, TIMEOUT=16 -> apply after 16 PENDING cycles, timeout_flag=1; next normal apply -> flag=0.
- 65537 vsync edges -> frame_cnt=1.
- Reset pulse mid-PENDING after write addr7=1 -> bypass=0, cfg_ready=1, no apply_pulse.

Source files
------------

// File: rtl/curve_param_ctrl.sv
// Curve parameter controller: shadow/active register sets with a vsync-aligned apply,
// timeout-forced apply, and a free-running vsync frame counter.
module curve_param_ctrl #(
  parameter logic [7:0]  LREF_D    = 8'd88,
  parameter logic [11:0] K_D       = 12'd587,
  parameter logic [11:0] PMAX_D    = 12'd587,
  parameter logic [11:0] ALPHA_H_D = 12'd561,
  parameter logic [7:0]  LB_D      = 8'd26,
  parameter logic [11:0] K2_D      = 12'd2040,
  parameter logic [3:0]  SMOOTH_D  = 4'd0,
  parameter logic [23:0] TIMEOUT   = 24'd2000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_vs,
  input  logic        cfg_wr,
  input  logic [2:0]  cfg_addr,
  input  logic [15:0] cfg_wdata,
  input  logic        cfg_commit,
  output logic        cfg_ready,
  output logic        cfg_err,
  output logic [7:0]  lref_q,
  output logic [11:0] k_q,
  output logic [11:0] pmax_q,
  output logic [11:0] alpha_h_q,
  output logic [7:0]  lb_q,
  output logic [11:0] k2_q,
  output logic [3:0]  smooth_k,
  output logic        bypass,
  output logic        apply_pulse,
  output logic        timeout_flag,
  output logic [15:0] frame_cnt
);

  localparam int unsigned W_B8  = 8;
  localparam int unsigned W_B12 = 12;
  localparam int unsigned W_SM  = 4;
  localparam int unsigned W_TO  = 24;
  localparam int unsigned W_FC  = 16;

  typedef struct packed {
    logic [W_B8-1:0]  lref;
    logic [W_B12-1:0] k;
    logic [W_B12-1:0] pmax;
    logic [W_B12-1:0] alpha_h;
    logic [W_B8-1:0]  lb;
    logic [W_B12-1:0] k2;
    logic [W_SM-1:0]  smooth;
    logic             bypass;
  } param_set_t;

  localparam param_set_t DEF_SET = '{
    lref: LREF_D, k: K_D, pmax: PMAX_D, alpha_h: ALPHA_H_D,
    lb: LB_D, k2: K2_D, smooth: SMOOTH_D, bypass: 1'b0
  };

  typedef enum logic [1:0] {IDLE, PENDING, APPLY} state_t;

  state_t          state, state_nxt;
  param_set_t      shadow, shadow_nxt;
  param_set_t      active, active_nxt;
  logic            vs_q;
  logic            vs_rise_c;
  logic [W_TO-1:0] to_cnt, to_cnt_nxt;
  logic            forced, forced_nxt;
  logic            ready_nxt, err_nxt, pulse_nxt, flag_nxt;
  logic [W_FC-1:0] frame_nxt;

  assign vs_rise_c = i_vs & ~vs_q;

  // Next-state, shadow/active update and registered-output next values
  always_comb begin
    state_nxt  = state;
    shadow_nxt = shadow;
    active_nxt = active;
    to_cnt_nxt = to_cnt;
    forced_nxt = forced;
    err_nxt    = 1'b0;
    pulse_nxt  = 1'b0;
    flag_nxt   = timeout_flag;
    frame_nxt  = frame_cnt + W_FC'(vs_rise_c);

    case (state)
      IDLE: begin
        if (cfg_wr) begin
          case (cfg_addr)
            3'd0: shadow_nxt.lref    = W_B8'(cfg_wdata);
            3'd1: shadow_nxt.k       = W_B12'(cfg_wdata);
            3'd2: shadow_nxt.pmax    = W_B12'(cfg_wdata);
            3'd3: shadow_nxt.alpha_h = W_B12'(cfg_wdata);
            3'd4: shadow_nxt.lb      = W_B8'(cfg_wdata);
            3'd5: shadow_nxt.k2      = W_B12'(cfg_wdata);
            3'd6: shadow_nxt.smooth  = W_SM'(cfg_wdata);
            default: shadow_nxt.bypass = cfg_wdata[0];
          endcase
        end
        // An edge coincident with commit is not consumed: PENDING only sees later edges
        if (cfg_commit) begin
          state_nxt  = PENDING;
          to_cnt_nxt = '0;
          forced_nxt = 1'b0;
        end
      end
      PENDING: begin
        err_nxt = cfg_wr;
        if (vs_rise_c) begin
          state_nxt  = APPLY;
          forced_nxt = 1'b0;
        end else if (to_cnt == TIMEOUT - W_TO'(1)) begin
          state_nxt  = APPLY;
          forced_nxt = 1'b1;
          flag_nxt   = 1'b1;
        end else begin
          to_cnt_nxt = to_cnt + W_TO'(1);
        end
      end
      APPLY: begin
        err_nxt    = cfg_wr;
        active_nxt = shadow;
        pulse_nxt  = 1'b1;
        to_cnt_nxt = '0;
        if (!forced) flag_nxt = 1'b0;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    ready_nxt = (state_nxt == IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shadow       <= DEF_SET;
      active       <= DEF_SET;
      vs_q         <= 1'b0;
      to_cnt       <= '0;
      forced       <= 1'b0;
      cfg_ready    <= 1'b1;
      cfg_err      <= 1'b0;
      apply_pulse  <= 1'b0;
      timeout_flag <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      state        <= state_nxt;
      shadow       <= shadow_nxt;
      active       <= active_nxt;
      vs_q         <= i_vs;
      to_cnt       <= to_cnt_nxt;
      forced       <= forced_nxt;
      cfg_ready    <= ready_nxt;
      cfg_err      <= err_nxt;
      apply_pulse  <= pulse_nxt;
      timeout_flag <= flag_nxt;
      frame_cnt    <= frame_nxt;
    end
  end

  assign lref_q    = active.lref;
  assign k_q       = active.k;
  assign pmax_q    = active.pmax;
  assign alpha_h_q = active.alpha_h;
  assign lb_q      = active.lb;
  assign k2_q      = active.k2;
  assign smooth_k  = active.smooth;
  assign bypass    = active.bypass;

endmodule

// File: tb/tb_curve_param_ctrl.sv
// Directed bench for curve_param_ctrl with hand-computed expectations (TIMEOUT=16).
module tb_curve_param_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_vs;
  logic        cfg_wr;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        cfg_commit;
  logic        cfg_ready;
  logic        cfg_err;
  logic [7:0]  lref_q;
  logic [11:0] k_q;
  logic [11:0] pmax_q;
  logic [11:0] alpha_h_q;
  logic [7:0]  lb_q;
  logic [11:0] k2_q;
  logic [3:0]  smooth_k;
  logic        bypass;
  logic        apply_pulse;
  logic        timeout_flag;
  logic [15:0] frame_cnt;

  int errors = 0;
  int checks = 0;

  curve_param_ctrl #(.TIMEOUT(24'd16)) dut (
    .clk(clk), .rst_n(rst_n), .i_vs(i_vs), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit), .cfg_ready(cfg_ready),
    .cfg_err(cfg_err), .lref_q(lref_q), .k_q(k_q), .pmax_q(pmax_q),
    .alpha_h_q(alpha_h_q), .lb_q(lb_q), .k2_q(k2_q), .smooth_k(smooth_k),
    .bypass(bypass), .apply_pulse(apply_pulse), .timeout_flag(timeout_flag),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [2:0] addr, input logic [15:0] data);
    cfg_wr = 1'b1; cfg_addr = addr; cfg_wdata = data;
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic vs_edge();
    i_vs = 1'b1; step();
    i_vs = 1'b0; step();
  endtask

  // Commit, one quiet PENDING cycle, then an edge; returns with apply_pulse expected high
  task automatic commit_and_edge();
    cfg_commit = 1'b1; step();
    cfg_commit = 1'b0; step();
    i_vs = 1'b1; step();
    i_vs = 1'b0; step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    i_vs = 1'b0; cfg_wr = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_commit = 1'b0;
    do_reset();

    check("rst_k", k_q, 587);
    check("rst_lref", lref_q, 88);
    check("rst_k2", k2_q, 2040);
    check("rst_alpha_h", alpha_h_q, 561);
    check("rst_lb", lb_q, 26);
    check("rst_ready", cfg_ready, 1);
    check("rst_pulse", apply_pulse, 0);
    check("rst_flag", timeout_flag, 0);
    check("rst_frame", frame_cnt, 0);

    // Edge-aligned apply latency
    write(3'd1, 16'd700);
    cfg_commit = 1'b1; step(); cfg_commit = 1'b0;
    check("pend_ready", cfg_ready, 0);
    step();
    check("pend_k_old", k_q, 587);
    i_vs = 1'b1; step();               // edge seen at this posedge (cycle N)
    i_vs = 1'b0;
    check("n1_k_old", k_q, 587);
    check("n1_pulse", apply_pulse, 0);
    step();                            // N+2
    check("n2_k_new", k_q, 700);
    check("n2_pulse", apply_pulse, 1);
    check("n2_ready", cfg_ready, 1);
    check("frame_one", frame_cnt, 1);
    step();
    check("pulse_one_cycle", apply_pulse, 0);

    // Field truncation and write coincident with commit
    write(3'd6, 16'h1235);
    cfg_wr = 1'b1; cfg_addr = 3'd5; cfg_wdata = 16'hFFFF; cfg_commit = 1'b1;
    step();
    cfg_wr = 1'b0; cfg_commit = 1'b0;
    step();
    i_vs = 1'b1; step(); i_vs = 1'b0; step();
    check("k2_trunc", k2_q, 4095);
    check("smooth_trunc", smooth_k, 5);
    check("k_kept", k_q, 700);

    // Write during PENDING is rejected; commit during PENDING is silent
    cfg_commit = 1'b1; step(); cfg_commit = 1'b0;
    cfg_wr = 1'b1; cfg_addr = 3'd0; cfg_wdata = 16'd10; step(); cfg_wr = 1'b0;
    check("err_pulse", cfg_err, 1);
    cfg_commit = 1'b1; step(); cfg_commit = 1'b0;
    check("err_one_cycle", cfg_err, 0);
    step();
    check("commit_pend_noerr", cfg_err, 0);
    i_vs = 1'b1; step(); i_vs = 1'b0; step();
    check("rej_pulse", apply_pulse, 1);
    check("rej_lref", lref_q, 88);

    // Commit coincident with an IDLE edge waits for the next edge
    write(3'd4, 16'h0133);
    cfg_commit = 1'b1; i_vs = 1'b1; step();
    cfg_commit = 1'b0; i_vs = 1'b0; step(); step();
    check("coinc_wait_ready", cfg_ready, 0);
    check("coinc_wait_lb", lb_q, 26);
    i_vs = 1'b1; step(); i_vs = 1'b0; step();
    check("coinc_pulse", apply_pulse, 1);
    check("coinc_lb", lb_q, 51);

    // Timeout-forced apply after 16 PENDING cycles
    write(3'd2, 16'd300);
    cfg_commit = 1'b1; step(); cfg_commit = 1'b0;
    for (int i = 0; i < 15; i++) step();
    check("to_still_pend", cfg_ready, 0);
    check("to_flag_pre", timeout_flag, 0);
    step();
    check("to_flag_set", timeout_flag, 1);
    check("to_no_pulse_yet", apply_pulse, 0);
    step();
    check("to_pulse", apply_pulse, 1);
    check("to_pmax", pmax_q, 300);
    check("to_flag_held", timeout_flag, 1);
    step();
    commit_and_edge();
    check("norm_pulse", apply_pulse, 1);
    check("norm_flag_clr", timeout_flag, 0);

    // Reset mid-PENDING discards the pending set
    write(3'd7, 16'd1);
    cfg_commit = 1'b1; step(); cfg_commit = 1'b0;
    step();
    rst_n = 1'b0; #1;
    check("rstp_bypass", bypass, 0);
    check("rstp_ready", cfg_ready, 1);
    check("rstp_pulse", apply_pulse, 0);
    check("rstp_pmax", pmax_q, 587);
    step();
    rst_n = 1'b1;
    step();
    vs_edge();
    check("rstp_no_pulse", apply_pulse, 0);
    check("rstp_bypass_after", bypass, 0);
    commit_and_edge();
    check("rstp_bypass_dflt", bypass, 0);

    // Frame counter wrap
    do_reset();
    for (int i = 0; i < 65535; i++) vs_edge();
    check("frame_max", frame_cnt, 65535);
    vs_edge();
    check("frame_wrap", frame_cnt, 0);
    vs_edge();
    check("frame_65537", frame_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
